// File: rtl/noc2validready_handshake_adapter_if.sv
// Bundles the NoC ejection side (flit push plus per-VC avail) and the
// valid/ready output side of the adapter.
interface noc2validready_handshake_adapter_if #(
  parameter int unsigned NumVirtualChannels    = 2,
  parameter int unsigned VirtualChannelIdWidth = 1,
  parameter int unsigned FlitWidth             = 64
);
  logic                             noc_valid;
  logic [VirtualChannelIdWidth-1:0] noc_virtual_channel;
  logic [FlitWidth-1:0]             noc_data;
  logic [NumVirtualChannels-1:0]    noc_avail;
  logic                             valid;
  logic                             ready;
  logic [VirtualChannelIdWidth-1:0] virtual_channel_id;
  logic [FlitWidth-1:0]             data;

  // Upstream router plus downstream IP, seen as a single peer
  modport master (
    output noc_valid, noc_virtual_channel, noc_data, ready,
    input  noc_avail, valid, virtual_channel_id, data
  );

  // The adapter itself
  modport slave (
    input  noc_valid, noc_virtual_channel, noc_data, ready,
    output noc_avail, valid, virtual_channel_id, data
  );
endinterface

// File: rtl/noc2validready_handshake_adapter.sv
// NoC ejection adapter: per-VC FIFOs fed under avail flow control, drained by a
// round-robin VC arbiter into a registered valid/ready output stage.
module noc2validready_handshake_adapter #(
  parameter int unsigned NumVirtualChannels    = 2,
  parameter int unsigned VirtualChannelIdWidth = 1,
  parameter int unsigned FlitWidth             = 64,
  parameter int unsigned BufferDepth           = 4
) (
  input logic clk,
  input logic rst_n,
  noc2validready_handshake_adapter_if.slave bus
);
  localparam int unsigned PtrWidth = $clog2(BufferDepth);
  localparam int unsigned OccWidth = PtrWidth + 1;

  typedef logic [OccWidth-1:0]              ptr_t;
  typedef logic [VirtualChannelIdWidth-1:0] vc_t;

  logic [FlitWidth-1:0]          mem_q [NumVirtualChannels][BufferDepth];
  ptr_t                          wr_ptr_q [NumVirtualChannels];
  ptr_t                          rd_ptr_q [NumVirtualChannels];
  logic [NumVirtualChannels-1:0] avail_q;
  vc_t                           rr_ptr_q;
  logic                          valid_q;
  vc_t                           vc_id_q;
  logic [FlitWidth-1:0]          data_q;

  logic [NumVirtualChannels-1:0] empty_c;
  logic [NumVirtualChannels-1:0] push_c;
  logic [NumVirtualChannels-1:0] pop_c;
  logic [NumVirtualChannels-1:0] avail_c;
  ptr_t                          occ_next_c;
  vc_t                           grant_c;
  logic                          grant_found_c;
  logic                          load_c;
  logic [FlitWidth-1:0]          head_c;

  // Pushes without avail, or to a VC id that does not exist, match no FIFO and are dropped
  always_comb begin
    empty_c = '0;
    push_c  = '0;
    for (int unsigned v = 0; v < NumVirtualChannels; v++) begin
      empty_c[v] = (wr_ptr_q[v] == rd_ptr_q[v]);
      push_c[v]  = bus.noc_valid && avail_q[v] && (bus.noc_virtual_channel == vc_t'(v));
    end
  end

  // Round-robin: first non-empty VC at or after the RR pointer
  always_comb begin
    grant_c       = '0;
    grant_found_c = 1'b0;
    for (int unsigned i = 0; i < NumVirtualChannels; i++) begin
      for (int unsigned v = 0; v < NumVirtualChannels; v++) begin
        if (!grant_found_c && !empty_c[v] &&
            (((32'(rr_ptr_q) + i) % NumVirtualChannels) == v)) begin
          grant_c       = vc_t'(v);
          grant_found_c = 1'b1;
        end
      end
    end
  end

  assign load_c = (!valid_q || bus.ready) && grant_found_c;

  // Pop select, head mux and next-state avail including this edge's push and pop
  always_comb begin
    pop_c      = '0;
    avail_c    = '0;
    head_c     = '0;
    occ_next_c = '0;
    for (int unsigned v = 0; v < NumVirtualChannels; v++) begin
      if (grant_c == vc_t'(v)) begin
        pop_c[v] = load_c;
        head_c   = mem_q[v][rd_ptr_q[v][PtrWidth-1:0]];
      end
      occ_next_c = wr_ptr_q[v] - rd_ptr_q[v] + ptr_t'(push_c[v]) - ptr_t'(pop_c[v]);
      avail_c[v] = (occ_next_c < ptr_t'(BufferDepth));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned v = 0; v < NumVirtualChannels; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
      end
      avail_q  <= '0;
      rr_ptr_q <= '0;
      valid_q  <= 1'b0;
      vc_id_q  <= '0;
      data_q   <= '0;
    end else begin
      avail_q <= avail_c;
      for (int unsigned v = 0; v < NumVirtualChannels; v++) begin
        if (push_c[v]) wr_ptr_q[v] <= wr_ptr_q[v] + ptr_t'(1);
        if (pop_c[v])  rd_ptr_q[v] <= rd_ptr_q[v] + ptr_t'(1);
      end
      if (load_c) begin
        valid_q  <= 1'b1;
        data_q   <= head_c;
        vc_id_q  <= grant_c;
        rr_ptr_q <= (32'(grant_c) == NumVirtualChannels - 1) ? '0 : grant_c + vc_t'(1);
      end else if (bus.ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Flit storage carries no reset; occupancy is tracked solely by the pointers
  always_ff @(posedge clk) begin
    for (int unsigned v = 0; v < NumVirtualChannels; v++) begin
      if (push_c[v]) mem_q[v][wr_ptr_q[v][PtrWidth-1:0]] <= bus.noc_data;
    end
  end

  assign bus.noc_avail          = avail_q;
  assign bus.valid              = valid_q;
  assign bus.virtual_channel_id = vc_id_q;
  assign bus.data               = data_q;
endmodule

// File: tb/tb_noc2validready_handshake_adapter.sv
// Directed bench: expected output flits are queued when stimulus is issued and
// a negedge monitor pops and compares them on every output handshake.
module tb_noc2validready_handshake_adapter;
  localparam int unsigned Nvc = 2;
  localparam int unsigned Vw  = 1;
  localparam int unsigned Fw  = 64;
  localparam int unsigned Dep = 4;

  typedef struct packed {
    logic [Vw-1:0] vc;
    logic [Fw-1:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   passes;
  int   hs_count;
  int   viol_count;
  int   hs_mark;
  exp_t sb [$];

  noc2validready_handshake_adapter_if #(
    .NumVirtualChannels(Nvc), .VirtualChannelIdWidth(Vw), .FlitWidth(Fw)
  ) bus ();

  noc2validready_handshake_adapter #(
    .NumVirtualChannels(Nvc), .VirtualChannelIdWidth(Vw),
    .FlitWidth(Fw), .BufferDepth(Dep)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [Vw-1:0] vc, input logic [Fw-1:0] d);
    bus.noc_valid           = 1'b1;
    bus.noc_virtual_channel = vc;
    bus.noc_data            = d;
    step();
    bus.noc_valid = 1'b0;
  endtask

  task automatic expect_flit(input logic [Vw-1:0] vc, input logic [Fw-1:0] d);
    exp_t e;
    e.vc   = vc;
    e.data = d;
    sb.push_back(e);
  endtask

  // Output monitor: every handshake must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && bus.valid && bus.ready) begin
      hs_count++;
      if (sb.size() == 0) begin
        check("unexpected_flit", bus.data, 64'hDEAD_0000_0000_DEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", bus.data, e.data);
        check("out_vc", 64'(bus.virtual_channel_id), 64'(e.vc));
      end
    end
  end

  // Flow-control violation detector (push to a VC without avail, or bad VC id)
  always @(negedge clk) begin
    if (rst_n && bus.noc_valid &&
        ((32'(bus.noc_virtual_channel) >= Nvc) || !bus.noc_avail[bus.noc_virtual_channel])) begin
      viol_count++;
      $display("note: upstream push without avail on vc %0d (flit dropped)", bus.noc_virtual_channel);
    end
  end

  initial begin
    checks = 0; passes = 0; hs_count = 0; viol_count = 0;
    rst_n = 1'b0;
    bus.noc_valid = 1'b0; bus.noc_virtual_channel = '0; bus.noc_data = '0; bus.ready = 1'b0;
    step(); step();
    check("rst_valid", 64'(bus.valid), 64'd0);
    check("rst_avail", 64'(bus.noc_avail), 64'd0);
    check("rst_data", bus.data, 64'd0);
    check("rst_vc", 64'(bus.virtual_channel_id), 64'd0);
    rst_n = 1'b1;
    #1;
    check("avail_before_edge", 64'(bus.noc_avail), 64'd0);
    step();
    check("avail_after_release", 64'(bus.noc_avail), 64'h3);

    // T1: single flit, one-cycle latency to valid
    bus.ready = 1'b1;
    expect_flit(1'b1, 64'hA5);
    push(1'b1, 64'hA5);
    check("t1_valid_edge_t", 64'(bus.valid), 64'd0);
    step();
    check("t1_valid_edge_t1", 64'(bus.valid), 64'd1);
    check("t1_data", bus.data, 64'hA5);
    check("t1_vc", 64'(bus.virtual_channel_id), 64'd1);
    step();
    check("t1_valid_drop", 64'(bus.valid), 64'd0);

    // T2: fill VC0 behind a stalled output
    bus.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_flit(1'b0, 64'(32'h30 + i));
      push(1'b0, 64'(32'h30 + i));
      if (i == 3) check("t2_avail_not_full", 64'(bus.noc_avail), 64'h3);
    end
    check("t2_avail_full", 64'(bus.noc_avail), 64'h2);

    // T3: stalled output is stable, then drains one per cycle
    for (int i = 0; i < 10; i++) begin
      step();
      check("t3_hold_valid", 64'(bus.valid), 64'd1);
      check("t3_hold_data", bus.data, 64'h30);
      check("t3_hold_vc", 64'(bus.virtual_channel_id), 64'd0);
    end
    bus.ready = 1'b1;
    hs_mark = hs_count;
    step();
    check("t3_avail_reraise", 64'(bus.noc_avail), 64'h3);
    for (int i = 0; i < 4; i++) step();
    check("t3_throughput", 64'(hs_count - hs_mark), 64'd5);
    check("t3_valid_empty", 64'(bus.valid), 64'd0);

    // T4: both VCs loaded, round-robin alternation
    bus.ready = 1'b0;
    for (int i = 0; i < 4; i++) push(1'b0, 64'(32'h10 + i));
    for (int i = 0; i < 4; i++) push(1'b1, 64'(32'h20 + i));
    for (int i = 0; i < 4; i++) begin
      expect_flit(1'b0, 64'(32'h10 + i));
      expect_flit(1'b1, 64'(32'h20 + i));
    end
    check("t4_avail", 64'(bus.noc_avail), 64'h1);
    check("t4_head", bus.data, 64'h10);
    bus.ready = 1'b1;
    hs_mark = hs_count;
    for (int i = 0; i < 8; i++) step();
    check("t4_count", 64'(hs_count - hs_mark), 64'd8);
    check("t4_valid_empty", 64'(bus.valid), 64'd0);

    // T6: push while VC0 has no avail is dropped
    bus.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_flit(1'b0, 64'(32'h40 + i));
      push(1'b0, 64'(32'h40 + i));
    end
    check("t6_avail_full", 64'(bus.noc_avail), 64'h2);
    push(1'b0, 64'h99);
    check("t6_violation_seen", 64'(viol_count), 64'd1);
    check("t6_avail_unchanged", 64'(bus.noc_avail), 64'h2);
    check("t6_head", bus.data, 64'h40);
    bus.ready = 1'b1;
    hs_mark = hs_count;
    for (int i = 0; i < 6; i++) step();
    check("t6_drain_count", 64'(hs_count - hs_mark), 64'd5);
    check("t6_valid_empty", 64'(bus.valid), 64'd0);

    // T5: reset mid-stream discards everything
    bus.ready = 1'b0;
    for (int i = 0; i < 5; i++) push(1'b0, 64'(32'h50 + i));
    check("t5_pre_valid", 64'(bus.valid), 64'd1);
    check("t5_pre_avail", 64'(bus.noc_avail), 64'h2);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 64'(bus.valid), 64'd0);
    check("t5_rst_avail", 64'(bus.noc_avail), 64'd0);
    check("t5_rst_data", bus.data, 64'd0);
    bus.ready = 1'b1;
    step(); step();
    rst_n = 1'b1;
    hs_mark = hs_count;
    step();
    check("t5_avail_release", 64'(bus.noc_avail), 64'h3);
    for (int i = 0; i < 6; i++) step();
    check("t5_no_stale", 64'(hs_count - hs_mark), 64'd0);
    check("t5_valid_idle", 64'(bus.valid), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
